// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller and its output buffer.
// The read-credit rule lives here so the controller and the buffer agree on the buffer size.
package ram_fifo_ctrl_pkg;

    localparam int OBUF_ENTRIES = 2;

    typedef logic [1:0] obuf_cnt_t;

    // A new RAM read may issue only if every word already owed to the buffer still leaves a free slot.
    function automatic logic read_credit_ok(input obuf_cnt_t obuf_cnt,
                                            input logic      inflight,
                                            input logic      m_fire);
        logic [2:0] pending;
        pending = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, m_fire};
        return (pending < 3'(OBUF_ENTRIES));
    endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry ordered output buffer that absorbs the RAM read latency.
// The head entry is registered and drives the consumer data directly.
module ram_fifo_obuf
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output obuf_cnt_t     cnt_o,
    output logic [DW-1:0] head_data_o
);

    obuf_cnt_t     cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data_i;
                else               tail_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the incoming word lands behind whatever remains.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    assign cnt_o       = cnt_q;
    assign head_data_o = head_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (1-cycle read, write-first on collision),
// with valid/ready on both sides and a 2-entry output buffer for 1 word/cycle throughput.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW+1:0] count,
    output logic          ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] RAM_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q, inflight_d;

    obuf_cnt_t     obuf_cnt;
    logic          s_fire;
    logic          m_fire;

    assign s_ready = (ram_cnt_q != RAM_FULL) & ~rst;
    assign s_fire  = s_valid & s_ready;
    assign m_valid = (obuf_cnt != 2'd0) & ~rst;
    assign m_fire  = m_valid & m_ready;

    // With the RAM empty, a same-cycle write can be read straight back via the RAM's collision forwarding.
    assign ram_ren    = ((ram_cnt_q != '0) | s_fire)
                      & read_credit_ok(obuf_cnt, inflight_q, m_fire) & ~rst;
    assign ram_r_addr = rptr_q;

    assign ram_wen    = s_fire;
    assign ram_w_addr = wptr_q;
    assign ram_w_data = s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        wptr_d     = s_fire  ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = ram_ren ? rptr_q + AW'(1) : rptr_q;
        ram_cnt_d  = ram_cnt_q + (AW + 1)'(s_fire) - (AW + 1)'(ram_ren);
        inflight_d = ram_ren;
    end

    ram_fifo_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (ram_r_data),
        .pop_i       (m_fire),
        .cnt_o       (obuf_cnt),
        .head_data_o (m_data)
    );

    always_comb begin
        if (rst) count = '0;
        else     count = (AW + 2)'(ram_cnt_q) + (AW + 2)'(inflight_q) + (AW + 2)'(obuf_cnt);
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a small attached RAM and a queue-level reference model.
module tb_ram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_wen;
    logic [AW-1:0] ram_w_addr;
    logic [DW-1:0] ram_w_data;
    logic          ram_ren;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_r_data;

    int n_checks = 0;
    int n_pass   = 0;

    ram_fifo_ctrl #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .ram_wen    (ram_wen),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .ram_ren    (ram_ren),
        .ram_r_addr (ram_r_addr),
        .ram_r_data (ram_r_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- attached RAM: 1-cycle read, new data on collision ----------------
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ren) ram_r_data <= (ram_wen && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr];
        if (ram_wen) mem[ram_w_addr] <= ram_w_data;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Each held word is tracked by where it sits: 0 = in RAM, 1 = read requested, 2 = visible to consumer.
    typedef struct {
        logic [DW-1:0] data;
        int            stage;
    } ent_t;

    ent_t mq[$];
    ent_t new_ent;
    int   wcnt, rcnt;
    int   n0, n1, n2;
    logic e_sready, e_mvalid, e_ren, e_sfire, e_mfire;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_ram_wen", ram_wen, 0);
            chk("rst_ram_ren", ram_ren, 0);
            mq.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            n0 = 0; n1 = 0; n2 = 0;
            foreach (mq[i]) begin
                if (mq[i].stage == 0)      n0++;
                else if (mq[i].stage == 1) n1++;
                else                       n2++;
            end
            e_sready = (n0 != DEPTH);
            e_mvalid = (mq.size() > 0) && (mq[0].stage == 2);
            e_sfire  = s_valid && e_sready;
            e_mfire  = e_mvalid && m_ready;
            e_ren    = (n0 != 0 || e_sfire) && (n1 + n2 - (e_mfire ? 1 : 0) < 2);

            chk("s_ready", s_ready, e_sready);
            chk("m_valid", m_valid, e_mvalid);
            chk("count", count, mq.size());
            chk("ram_wen", ram_wen, e_sfire);
            chk("ram_ren", ram_ren, e_ren);
            if (e_mvalid) chk("m_data", m_data, mq[0].data);
            if (e_sfire) begin
                chk("ram_w_addr", ram_w_addr, wcnt % DEPTH);
                chk("ram_w_data", ram_w_data, s_data);
            end
            if (e_ren) chk("ram_r_addr", ram_r_addr, rcnt % DEPTH);

            if (e_mfire) void'(mq.pop_front());
            foreach (mq[i]) if (mq[i].stage == 1) mq[i].stage = 2;
            if (e_sfire) begin
                new_ent.data  = s_data;
                new_ent.stage = 0;
                mq.push_back(new_ent);
                wcnt++;
            end
            if (e_ren) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].stage == 0) begin
                        mq[i].stage = 1;
                        break;
                    end
                end
                rcnt++;
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    int acc;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", count, 0);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_m_valid", m_valid, 0);

        // Single word: write and read collide at address 0, visible two cycles later.
        step(); s_valid = 1'b1; s_data = 32'hA5A5_0001; m_ready = 1'b1;
        @(negedge clk);
        chk("single_wen", ram_wen, 1);
        chk("single_ren", ram_ren, 1);
        chk("single_waddr", ram_w_addr, 0);
        chk("single_raddr", ram_r_addr, 0);
        step(); s_valid = 1'b0;
        @(negedge clk);
        chk("single_t1_m_valid", m_valid, 0);
        chk("single_t1_count", count, 1);
        step();
        @(negedge clk);
        chk("single_t2_m_valid", m_valid, 1);
        chk("single_t2_m_data", m_data, 32'hA5A5_0001);
        step();
        @(negedge clk);
        chk("single_t3_count", count, 0);

        // Streaming 0..99 with both sides always willing.
        for (int i = 0; i < 102; i++) begin
            step(); s_valid = (i < 100); s_data = DW'(i); m_ready = 1'b1;
            @(negedge clk);
            chk("stream_count_le3", (count <= 3), 1);
            if (i >= 2) begin
                chk("stream_m_valid", m_valid, 1);
                chk("stream_m_data", m_data, i - 2);
            end
        end
        step(); s_valid = 1'b0;
        repeat (4) step();

        // Fill to full with the consumer stalled.
        m_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            step(); s_valid = 1'b1; s_data = 32'h100 + DW'(acc);
            @(negedge clk);
            if (s_ready) acc++;
        end
        chk("full_accepted", acc, 10);
        chk("full_count", count, 10);
        chk("full_s_ready", s_ready, 0);
        step(); m_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_no_reopen", s_ready, 0);
        step(); m_ready = 1'b0;
        @(negedge clk);
        chk("full_reopen", s_ready, 1);
        step(); s_valid = 1'b0;
        @(negedge clk);
        chk("full_count_after", count, 10);
        m_ready = 1'b1;
        repeat (16) step();

        // Simultaneous push and pop at count 5.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); s_valid = 1'b1; s_data = $urandom;
        end
        step(); s_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("simul_count_before", count, 5);
        step(); s_valid = 1'b1; s_data = $urandom; m_ready = 1'b1;
        step(); s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("simul_count_after", count, 5);
        m_ready = 1'b1;
        repeat (10) step();

        // Random traffic across many pointer wraps.
        for (int k = 0; k < 120; k++) begin
            step();
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            m_ready = (k < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        end
        step(); s_valid = 1'b0; m_ready = 1'b1;
        repeat (16) step();

        // Reset with a read outstanding and words buffered.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); s_valid = 1'b1; s_data = 32'hDEAD_0000 + DW'(k);
        end
        step(); s_valid = 1'b0;
        repeat (3) step();
        step(); s_valid = 1'b1; s_data = 32'hDEAD_0100; m_ready = 1'b1;
        step(); rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_s_ready", s_ready, 1);
        step(); s_valid = 1'b1; s_data = 32'h1234; m_ready = 1'b1;
        step(); s_valid = 1'b0;
        step();
        @(negedge clk);
        chk("midrst_first_valid", m_valid, 1);
        chk("midrst_first_data", m_data, 32'h1234);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
